// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the 32-bit single-bus
// datapath. Sequences fetch (T0-T2) and execution (T3-T6) of register-register
// ALU instructions, decoding the instruction held in IR.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        Done,
  output logic        Halted
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t state, next;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_tri, is_md, is_un;
  logic [11:0] op_sel;
  logic [11:0] alu;
  logic        unused_ir;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // ALU select vector ordered {AND,OR,ADD,SUB,MUL,DIV,SHR,SHL,ROR,ROL,NEG,NOT}
  function automatic logic [11:0] alu_decode(input logic [4:0] opc);
    case (opc)
      5'b00101: return 12'd1 << 11;
      5'b00110: return 12'd1 << 10;
      5'b00011: return 12'd1 << 9;
      5'b00100: return 12'd1 << 8;
      5'b01111: return 12'd1 << 7;
      5'b10000: return 12'd1 << 6;
      5'b00111: return 12'd1 << 5;
      5'b01000: return 12'd1 << 4;
      5'b01001: return 12'd1 << 3;
      5'b01010: return 12'd1 << 2;
      5'b10001: return 12'd1 << 1;
      5'b10010: return 12'd1;
      default:  return 12'd0;
    endcase
  endfunction

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign op_sel    = alu_decode(opcode);
  assign is_tri    = (opcode >= 5'b00011) && (opcode <= 5'b01010);
  assign is_md     = (opcode == 5'b01111) || (opcode == 5'b10000);
  assign is_un     = (opcode == 5'b10001) || (opcode == 5'b10010);

  assign {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT} = alu;

  // State register; Clear wins over every other input
  always_ff @(posedge Clock) begin
    if (Clear) state <= IDLE;
    else       state <= next;
  end

  // Next-state and Moore outputs from state plus the decoded IR
  always_comb begin
    next    = state;
    PCout   = 1'b0;
    MDRout  = 1'b0;
    Zhiout  = 1'b0;
    Zlowout = 1'b0;
    HIout   = 1'b0;
    LOout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    Read    = 1'b0;
    Rout    = 16'd0;
    Rin     = 16'd0;
    alu     = 12'd0;
    Done    = 1'b0;
    Halted  = 1'b0;
    case (state)
      IDLE: if (Run) next = T0;
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        next  = T1;
      end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (MemReady) next = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        next   = T3;
      end
      T3: begin
        next = T4;
        if (is_tri) begin
          Rout = onehot16(rb);
          Yin  = 1'b1;
        end else if (is_md) begin
          Rout = onehot16(ra);
          Yin  = 1'b1;
        end else if (is_un) begin
          Rout = onehot16(rb);
          alu  = op_sel;
          Zin  = 1'b1;
        end else begin
          next = HALT;
        end
      end
      T4: begin
        next = HALT;
        if (is_tri) begin
          Rout = onehot16(rc);
          alu  = op_sel;
          Zin  = 1'b1;
          next = T5;
        end else if (is_md) begin
          Rout = onehot16(rb);
          alu  = op_sel;
          Zin  = 1'b1;
          next = T5;
        end else if (is_un) begin
          Zlowout = 1'b1;
          Rin     = onehot16(ra);
          Done    = 1'b1;
          next    = Run ? T0 : IDLE;
        end
      end
      T5: begin
        next = HALT;
        if (is_tri) begin
          Zlowout = 1'b1;
          Rin     = onehot16(ra);
          Done    = 1'b1;
          next    = Run ? T0 : IDLE;
        end else if (is_md) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
          next    = T6;
        end
      end
      T6: begin
        next = HALT;
        if (is_md) begin
          Zhiout = 1'b1;
          HIin   = 1'b1;
          Done   = 1'b1;
          next   = Run ? T0 : IDLE;
        end
      end
      HALT: Halted = 1'b1;
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench. The driver expands each instruction
// into its expected per-cycle control words from the instruction tables and
// queues them; a negedge monitor pops and compares against the DUT outputs.
module tb_control_sequencer;

  typedef struct packed {
    logic        pcout, mdrout, zhiout, zlowout, hiout, loout;
    logic        pcin, incpc, marin, mdrin, irin, yin, zin, hiin, loin, read;
    logic [15:0] rout, rin;
    logic [11:0] alu;
    logic        done, halted;
  } cw_t;

  typedef struct {
    cw_t        exp;
    logic       mr;
    logic       real_ir;
    logic       last;
  } step_t;

  logic        Clock = 1'b0;
  logic        Clear, Run, MemReady;
  logic [31:0] IR;
  logic PCout, MDRout, Zhiout, Zlowout, HIout, LOout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Read;
  logic [15:0] Rout, Rin;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;
  logic Done, Halted;

  cw_t act;
  cw_t sb[$];
  int  checks = 0;
  int  passes = 0;
  int  mon_cycle = 0;

  // 0 = idle, 1 = about to be in T0, 2 = halted
  int  where = 0;

  // Opcodes in ALU-select order AND..NOT
  int  opc_tab[12] = '{5, 6, 3, 4, 15, 16, 7, 8, 9, 10, 17, 18};

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .MDRout(MDRout), .Zhiout(Zhiout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .Read(Read), .Rout(Rout), .Rin(Rin),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Done(Done), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  assign act = {PCout, MDRout, Zhiout, Zlowout, HIout, LOout,
                PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Read,
                Rout, Rin,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
                Done, Halted};

  // Monitor: every cycle with a queued expectation is compared mid-cycle
  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      cw_t e;
      e = sb.pop_front();
      checks++;
      if (act === e) passes++;
      else $display("FAIL cw@%0d got=%016h want=%016h", mon_cycle, act, e);
    end
    mon_cycle++;
  end

  function automatic logic rbit();
    return logic'($urandom_range(1));
  endfunction

  function automatic logic [31:0] rword();
    return $urandom;
  endfunction

  function automatic int op_index(input logic [4:0] opc);
    for (int i = 0; i < 12; i++)
      if (opc_tab[i] == int'(opc)) return i;
    return -1;
  endfunction

  task automatic cycle(input cw_t exp, input logic run, input logic mr,
                       input logic [31:0] ir, input logic clr, input bit chk);
    Run = run; MemReady = mr; IR = ir; Clear = clr;
    if (chk) sb.push_back(exp);
    @(posedge Clock);
    #1;
  endtask

  // Expand one instruction into cycles; assumes the DUT is in T0 now.
  // abort_at >= 0 asserts Clear on that step index (clipped to the length).
  task automatic do_instr(input logic [31:0] ir, input int waits,
                          input logic run_done, input int abort_at);
    step_t s[$];
    step_t t;
    cw_t   w;
    int    k;
    int    ab;
    logic  [15:0] ra_oh, rb_oh, rc_oh;
    logic  [11:0] alu_bit;
    ra_oh = 16'd1 << ir[26:23];
    rb_oh = 16'd1 << ir[22:19];
    rc_oh = 16'd1 << ir[18:15];
    k = op_index(ir[31:27]);
    alu_bit = (k >= 0) ? (12'd1 << (11 - k)) : 12'd0;

    w = '0; w.pcout = 1; w.marin = 1; w.incpc = 1;
    t.exp = w; t.mr = rbit(); t.real_ir = 0; t.last = 0; s.push_back(t);
    w = '0; w.read = 1; w.mdrin = 1;
    for (int i = 0; i <= waits; i++) begin
      t.exp = w; t.mr = (i == waits); s.push_back(t);
    end
    w = '0; w.mdrout = 1; w.irin = 1;
    t.exp = w; t.mr = rbit(); s.push_back(t);
    t.real_ir = 1;
    if (k < 0) begin
      t.exp = '0; t.mr = rbit(); s.push_back(t);
    end else if (k == 10 || k == 11) begin
      w = '0; w.rout = rb_oh; w.alu = alu_bit; w.zin = 1;
      t.exp = w; s.push_back(t);
      w = '0; w.zlowout = 1; w.rin = ra_oh; w.done = 1;
      t.exp = w; t.last = 1; s.push_back(t);
    end else if (k == 4 || k == 5) begin
      w = '0; w.rout = ra_oh; w.yin = 1; t.exp = w; s.push_back(t);
      w = '0; w.rout = rb_oh; w.alu = alu_bit; w.zin = 1; t.exp = w; s.push_back(t);
      w = '0; w.zlowout = 1; w.loin = 1; t.exp = w; s.push_back(t);
      w = '0; w.zhiout = 1; w.hiin = 1; w.done = 1;
      t.exp = w; t.last = 1; s.push_back(t);
    end else begin
      w = '0; w.rout = rb_oh; w.yin = 1; t.exp = w; s.push_back(t);
      w = '0; w.rout = rc_oh; w.alu = alu_bit; w.zin = 1; t.exp = w; s.push_back(t);
      w = '0; w.zlowout = 1; w.rin = ra_oh; w.done = 1;
      t.exp = w; t.last = 1; s.push_back(t);
    end

    ab = (abort_at >= s.size()) ? s.size() - 1 : abort_at;
    foreach (s[i]) begin
      if (i == ab) begin
        cycle(s[i].exp, rbit(), rbit(), s[i].real_ir ? ir : rword(), 1'b1, 1'b1);
        where = 0;
        return;
      end
      cycle(s[i].exp, s[i].last ? run_done : rbit(), s[i].mr,
            s[i].real_ir ? ir : rword(), 1'b0, 1'b1);
    end
    if (k < 0)         where = 2;
    else if (run_done) where = 1;
    else               where = 0;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {opc, a, b, c, 15'h5a5a};
  endfunction

  cw_t w_idle, w_halt;

  initial begin
    int n;
    logic [31:0] rv;
    logic [4:0]  opc;
    logic        r;
    w_idle = '0;
    w_halt = '0; w_halt.halted = 1;

    // Reset from unknown state, then idle with Run low
    cycle(w_idle, 1'b1, 1'b1, 32'hffff_ffff, 1'b1, 1'b0);
    cycle(w_idle, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    cycle(w_idle, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // ADD R2,R4,R5 with no memory wait, then drop to idle
    cycle(w_idle, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    do_instr(mk_ir(5'b00011, 4'd2, 4'd4, 4'd5), 0, 1'b0, -1);
    cycle(w_idle, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    // MUL with three wait cycles in T1
    do_instr(mk_ir(5'b01111, 4'd2, 4'd4, 4'd9), 3, 1'b1, -1);
    // Two NOTs back to back
    do_instr(mk_ir(5'b10010, 4'd7, 4'd1, 4'd0), 0, 1'b1, -1);
    do_instr(mk_ir(5'b10010, 4'd3, 4'd15, 4'd0), 0, 1'b1, -1);
    // Illegal opcode halts; Run toggling is ignored; Clear recovers
    do_instr(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b1, -1);
    for (int i = 0; i < 4; i++) cycle(w_halt, logic'(i[0]), 1'b1, rword(), 1'b0, 1'b1);
    cycle(w_halt, 1'b1, 1'b1, rword(), 1'b1, 1'b1);
    cycle(w_idle, 1'b1, 1'b0, rword(), 1'b0, 1'b1);
    // SUB cleared in T4 (step index 4 with no waits)
    do_instr(mk_ir(5'b00100, 4'd6, 4'd8, 4'd10), 0, 1'b1, 4);
    cycle(w_idle, 1'b0, 1'b1, rword(), 1'b0, 1'b1);
    cycle(w_idle, 1'b1, 1'b1, rword(), 1'b0, 1'b1);
    where = 1;

    // Randomized instruction stream
    n = 0;
    while (n < 60) begin
      if (where == 0) begin
        r = ($urandom_range(3) != 0);
        cycle(w_idle, r, rbit(), rword(), 1'b0, 1'b1);
        if (r) where = 1;
      end else if (where == 2) begin
        if ($urandom_range(3) == 0) begin
          cycle(w_halt, rbit(), rbit(), rword(), 1'b1, 1'b1);
          where = 0;
        end else begin
          cycle(w_halt, rbit(), rbit(), rword(), 1'b0, 1'b1);
        end
      end else begin
        rv = rword();
        if ($urandom_range(9) == 0) opc = 5'($urandom_range(31));
        else                        opc = 5'(opc_tab[$urandom_range(11)]);
        do_instr({opc, rv[26:0]}, $urandom_range(3), rbit(),
                 ($urandom_range(7) == 0) ? int'($urandom_range(9)) : -1);
        n++;
      end
    end

    cycle(w_idle, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(w_idle, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge Clock);
    #1;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain got=%0d want=0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
